// File: rtl/player_pkg.sv
// player_pkg: shared FSM states, button codes and screen defaults for player_mover
package player_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2, DEAD = 2'd3} state_t;
  localparam logic [3:0] BTN_U = 4'd8;
  localparam logic [3:0] BTN_D = 4'd4;
  localparam logic [3:0] BTN_R = 4'd2;
  localparam logic [3:0] BTN_L = 4'd1;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  function automatic int cnt_bits(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/player_step_calc.sv
// player_step_calc: next position on one axis after a single step, wrapping or clamping at the edges
module player_step_calc #(
  parameter int POS_W = 12,
  parameter int STEP  = 12
) (
  input  logic [POS_W-1:0] i_pos,
  input  logic [POS_W-1:0] i_size,
  input  logic [POS_W-1:0] i_limit,
  input  logic             i_inc,
  input  logic             i_wrap,
  output logic [POS_W-1:0] o_pos
);
  logic [POS_W:0] w_pos, w_size, w_lim, w_step, w_dec, w_inc;
  assign w_pos  = {1'b0, i_pos};
  assign w_size = {1'b0, i_size};
  assign w_lim  = {1'b0, i_limit};
  assign w_step = (POS_W+1)'(STEP);
  assign w_dec  = w_pos >= w_step ? w_pos - w_step : (i_wrap ? w_lim - w_size : '0);
  assign w_inc  = w_pos + w_size + w_step <= w_lim ? w_pos + w_step : (i_wrap ? '0 : w_lim - w_size);
  assign o_pos  = POS_W'(i_inc ? w_inc : w_dec);
endmodule

// File: rtl/player_mover.sv
// player_mover: player rectangle position controller with stepping, edge wrap/clamp, trap death and timed respawn; auto-repeat enabled by PLAYER_MOVER_REPEAT_EN
module player_mover
  import player_pkg::*;
#(
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int SCREEN_H       = DEF_SCREEN_H,
  parameter int POS_W          = 12,
  parameter int STEP           = 12,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_PERIOD  = 2,
  parameter int RESPAWN_CYCLES = 16
) (
  input  logic             btnClk,
  input  logic             rst,
  input  logic             playerDisable,
  input  logic             wrapMode,
  input  logic             upEnable,
  input  logic             downEnable,
  input  logic             leftEnable,
  input  logic             rightEnable,
  input  logic [3:0]       btns,
  input  logic [POS_W-1:0] hStartPos,
  input  logic [POS_W-1:0] vStartPos,
  input  logic [POS_W-1:0] objWidth,
  input  logic [POS_W-1:0] objHeight,
  output logic [POS_W-1:0] hPos,
  output logic [POS_W-1:0] vPos,
  output logic             moving,
  output logic             player_dead,
  output logic             dead,
  output logic [1:0]       state_o
);
  localparam int CNT_W = cnt_bits(REPEAT_DELAY, REPEAT_PERIOD, RESPAWN_CYCLES);
  state_t r_state, w_state_n;
  logic [POS_W-1:0] r_hpos, r_vpos, w_hnext, w_vnext;
  logic [CNT_W-1:0] r_dead_cnt;
  logic r_moving, r_player_dead, w_valid, w_trap, w_step, w_respawn, w_vert;
`ifdef PLAYER_MOVER_REPEAT_EN
  logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_n;
  logic [3:0] r_btn;
`endif
  assign w_valid = !playerDisable && ((btns == BTN_U && upEnable) || (btns == BTN_D && downEnable) ||
                                      (btns == BTN_R && rightEnable) || (btns == BTN_L && leftEnable));
  assign w_trap  = r_state != DEAD && !(upEnable || downEnable || leftEnable || rightEnable);
  assign w_vert  = btns[3] | btns[2];
  player_step_calc #(.POS_W(POS_W), .STEP(STEP)) u_h (
    .i_pos(r_hpos), .i_size(objWidth), .i_limit(POS_W'(SCREEN_W)),
    .i_inc(btns == BTN_R), .i_wrap(wrapMode), .o_pos(w_hnext)
  );
  player_step_calc #(.POS_W(POS_W), .STEP(STEP)) u_v (
    .i_pos(r_vpos), .i_size(objHeight), .i_limit(POS_W'(SCREEN_H)),
    .i_inc(btns == BTN_D), .i_wrap(wrapMode), .o_pos(w_vnext)
  );
  // next state, step request and respawn; trap outranks any press
  always_comb begin
    w_state_n = r_state;
    w_step    = 1'b0;
    w_respawn = 1'b0;
`ifdef PLAYER_MOVER_REPEAT_EN
    w_rep_cnt_n = r_rep_cnt;
`endif
    if (r_state == DEAD) begin
      w_respawn = RESPAWN_CYCLES != 0 && r_dead_cnt == CNT_W'(RESPAWN_CYCLES - 1);
      w_state_n = w_respawn ? IDLE : DEAD;
    end else if (w_trap) begin
      w_state_n = DEAD;
    end else begin
`ifdef PLAYER_MOVER_REPEAT_EN
      if (r_state == IDLE) begin
        w_step      = w_valid;
        w_state_n   = w_valid ? HOLD : IDLE;
        w_rep_cnt_n = '0;
      end else if (!w_valid) begin
        w_state_n   = IDLE;
        w_rep_cnt_n = '0;
      end else if (btns != r_btn) begin
        w_step      = 1'b1;
        w_state_n   = HOLD;
        w_rep_cnt_n = '0;
      end else if (r_rep_cnt == CNT_W'(r_state == HOLD ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1)) begin
        w_step      = 1'b1;
        w_state_n   = REPEAT;
        w_rep_cnt_n = '0;
      end else begin
        w_rep_cnt_n = r_rep_cnt + 1'b1;
      end
`else
      w_step = w_valid;
`endif
    end
  end
  // state, position, dead timer and registered pulses
  always_ff @(posedge btnClk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_hpos        <= hStartPos;
      r_vpos        <= vStartPos;
      r_dead_cnt    <= '0;
      r_moving      <= 1'b0;
      r_player_dead <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_dead_cnt    <= r_state == DEAD ? r_dead_cnt + 1'b1 : '0;
      r_moving      <= w_step;
      r_player_dead <= w_trap;
      if (w_respawn) begin
        r_hpos <= hStartPos;
        r_vpos <= vStartPos;
      end else if (w_step) begin
        if (w_vert) r_vpos <= w_vnext;
        else r_hpos <= w_hnext;
      end
    end
  end
`ifdef PLAYER_MOVER_REPEAT_EN
  // auto-repeat counter and the direction currently being held
  always_ff @(posedge btnClk) begin
    r_rep_cnt <= rst ? '0 : w_rep_cnt_n;
    r_btn     <= rst ? '0 : (w_step ? btns : r_btn);
  end
`endif
  assign hPos        = r_hpos;
  assign vPos        = r_vpos;
  assign moving      = r_moving;
  assign player_dead = r_player_dead;
  assign dead        = r_state == DEAD;
  assign state_o     = r_state;
endmodule
